// File: rtl/load_store_unit.sv
// Load/store unit: a single-request memory port with alignment checks, lane
// steering, sign extension, a bounded wait for MEM_ACK and a pipeline freeze.
module load_store_unit #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              CK_REF,
  input  logic              RST,
  input  logic              HALT,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WE,
  input  logic [2:0]        REQ_TYPE,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [31:0]       REQ_WDATA,
  input  logic [4:0]        REQ_RD,
  output logic              MEM_REQ,
  output logic              MEM_READ_WRN,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [3:0]        MEM_BYTE_EN,
  output logic [31:0]       MEM_WDATA,
  input  logic              MEM_ACK,
  input  logic [31:0]       MEM_RDATA,
  output logic              RSP_VALID,
  output logic [4:0]        RSP_RD,
  output logic [31:0]       RSP_DATA,
  output logic [1:0]        RSP_ERR,
  output logic              BUSY
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic [2:0] T_WORD  = 3'b000;
  localparam logic [2:0] T_UHALF = 3'b001;
  localparam logic [2:0] T_SHALF = 3'b010;
  localparam logic [2:0] T_UBYTE = 3'b011;
  localparam logic [2:0] T_SBYTE = 3'b100;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]        state;
  logic [7:0]        cnt;
  logic              we_r;
  logic [2:0]        type_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
  logic [4:0]        rd_r;
  logic [31:0]       rsp_data_r;
  logic [1:0]        rsp_err_r;

  function automatic logic is_bad_type(input logic [2:0] t);
    return t > T_SBYTE;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] t, input logic [1:0] off);
    logic m;
    m = 1'b0;
    if (t == T_WORD) m = (off != 2'b00);
    else if (t == T_UHALF || t == T_SHALF) m = off[0];
    return m;
  endfunction

  function automatic logic [3:0] lane_enable(input logic [2:0] t, input logic [1:0] off);
    logic [3:0] be;
    case (t)
      T_WORD:          be = 4'b1111;
      T_UHALF, T_SHALF: be = off[1] ? 4'b1100 : 4'b0011;
      default:         be = 4'b0001 << off;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] replicate(input logic [2:0] t, input logic [31:0] d);
    logic [31:0] r;
    case (t)
      T_WORD:          r = d;
      T_UHALF, T_SHALF: r = {d[15:0], d[15:0]};
      default:         r = {4{d[7:0]}};
    endcase
    return r;
  endfunction

  // Shift the addressed lane down to bit 0, then extend according to type.
  function automatic logic [31:0] extract(input logic [2:0] t, input logic [1:0] off,
                                          input logic [31:0] d);
    logic [31:0] sh;
    logic [31:0] r;
    sh = d >> {off, 3'b000};
    case (t)
      T_UHALF: r = {16'h0000, sh[15:0]};
      T_SHALF: r = {{16{sh[15]}}, sh[15:0]};
      T_UBYTE: r = {24'h000000, sh[7:0]};
      T_SBYTE: r = {{24{sh[7]}}, sh[7:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  always_ff @(posedge CK_REF) begin
    if (RST) begin
      state      <= S_IDLE;
      cnt        <= '0;
      we_r       <= 1'b0;
      type_r     <= '0;
      addr_r     <= '0;
      wdata_r    <= '0;
      rd_r       <= '0;
      rsp_data_r <= '0;
      rsp_err_r  <= '0;
    end else if (!HALT) begin
      case (state)
        S_IDLE: begin
          if (REQ_VALID) begin
            we_r       <= REQ_WE;
            type_r     <= REQ_TYPE;
            addr_r     <= REQ_ADDR;
            wdata_r    <= REQ_WDATA;
            rd_r       <= REQ_RD;
            cnt        <= '0;
            rsp_data_r <= '0;
            if (is_bad_type(REQ_TYPE)) begin
              rsp_err_r <= 2'b11;
              state     <= S_RESP;
            end else if (is_misaligned(REQ_TYPE, REQ_ADDR[1:0])) begin
              rsp_err_r <= 2'b01;
              state     <= S_RESP;
            end else begin
              rsp_err_r <= 2'b00;
              state     <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          // An ACK in the final allowed cycle still completes the access.
          if (MEM_ACK) begin
            rsp_data_r <= we_r ? 32'h0 : extract(type_r, addr_r[1:0], MEM_RDATA);
            state      <= S_RESP;
          end else if (cnt == CNT_LAST) begin
            rsp_err_r  <= 2'b10;
            rsp_data_r <= 32'h0;
            state      <= S_RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic in_access;
  logic in_resp;
  assign in_access = (state == S_ACCESS);
  assign in_resp   = (state == S_RESP);

  assign REQ_READY    = (state == S_IDLE) && !HALT && !RST;
  assign BUSY         = (state != S_IDLE);
  assign MEM_REQ      = in_access;
  assign MEM_READ_WRN = !(in_access && we_r);
  assign MEM_ADDR     = in_access ? {addr_r[ADDR_W-1:2], 2'b00} : '0;
  assign MEM_BYTE_EN  = in_access ? lane_enable(type_r, addr_r[1:0]) : 4'b0000;
  assign MEM_WDATA    = (in_access && we_r) ? replicate(type_r, wdata_r) : 32'h0;
  assign RSP_VALID    = in_resp;
  assign RSP_RD       = in_resp ? rd_r : 5'd0;
  assign RSP_DATA     = in_resp ? rsp_data_r : 32'h0;
  assign RSP_ERR      = in_resp ? rsp_err_r : 2'b00;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit; each task covers one scenario with
// hand-computed expectations sampled on the falling edge.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst, halt, req_valid, req_ready, req_we;
  logic [2:0]  req_type;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req, mem_read_wrn, mem_ack;
  logic [15:0] mem_addr;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_wdata, mem_rdata;
  logic        rsp_valid, busy;
  logic [4:0]  rsp_rd;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(16), .TIMEOUT(4)) dut (
    .CK_REF(clk), .RST(rst), .HALT(halt),
    .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WE(req_we),
    .REQ_TYPE(req_type), .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata), .REQ_RD(req_rd),
    .MEM_REQ(mem_req), .MEM_READ_WRN(mem_read_wrn), .MEM_ADDR(mem_addr),
    .MEM_BYTE_EN(mem_byte_en), .MEM_WDATA(mem_wdata),
    .MEM_ACK(mem_ack), .MEM_RDATA(mem_rdata),
    .RSP_VALID(rsp_valid), .RSP_RD(rsp_rd), .RSP_DATA(rsp_data), .RSP_ERR(rsp_err),
    .BUSY(busy)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for one cycle (cycle N); returns early in cycle N+1.
  task automatic issue(input logic we, input logic [2:0] t, input logic [15:0] a,
                       input logic [31:0] wd, input logic [4:0] rd);
    next_cycle();
    req_we = we; req_type = t; req_addr = a; req_wdata = wd; req_rd = rd;
    req_valid = 1'b1;
    next_cycle();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", req_ready); end
    checks++; if (mem_read_wrn !== 1'b1) begin errors++; $display("FAIL reset_rdwrn: got %b want 1", mem_read_wrn); end
    checks++; if ({mem_req, rsp_valid, busy, mem_byte_en} !== 7'b0) begin errors++; $display("FAIL reset_outs: got %b want 0", {mem_req, rsp_valid, busy, mem_byte_en}); end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_sbyte_load();
    issue(1'b0, 3'b100, 16'h0013, 32'h0, 5'd7);
    mem_ack = 1'b1; mem_rdata = 32'h80FF_1234;
    @(negedge clk);
    checks++; if ({mem_req, mem_read_wrn, mem_byte_en} !== 6'b11_1000) begin errors++; $display("FAIL sbyte_cmd: got %b want 111000", {mem_req, mem_read_wrn, mem_byte_en}); end
    checks++; if (mem_addr !== 16'h0010) begin errors++; $display("FAIL sbyte_addr: got %h want 0010", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL sbyte_wdata: got %h want 0", mem_wdata); end
    next_cycle();
    mem_ack = 1'b0;
    @(negedge clk);
    checks++; if ({rsp_valid, mem_req} !== 2'b10) begin errors++; $display("FAIL sbyte_rsp_timing: got %b want 10", {rsp_valid, mem_req}); end
    checks++; if (rsp_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL sbyte_data: got %h want ffffff80", rsp_data); end
    checks++; if ({rsp_err, rsp_rd} !== {2'b00, 5'd7}) begin errors++; $display("FAIL sbyte_err_rd: got %b want 0000111", {rsp_err, rsp_rd}); end
    next_cycle();
    @(negedge clk);
    checks++; if ({rsp_valid, req_ready, busy} !== 3'b010) begin errors++; $display("FAIL sbyte_done: got %b want 010", {rsp_valid, req_ready, busy}); end
  endtask

  task automatic test_half_store();
    issue(1'b1, 3'b001, 16'h0022, 32'h1234_ABCD, 5'd3);
    mem_ack = 1'b1;
    @(negedge clk);
    checks++; if ({mem_req, mem_read_wrn, mem_byte_en} !== 6'b10_1100) begin errors++; $display("FAIL hstore_cmd: got %b want 101100", {mem_req, mem_read_wrn, mem_byte_en}); end
    checks++; if (mem_wdata !== 32'hABCD_ABCD) begin errors++; $display("FAIL hstore_wdata: got %h want abcdabcd", mem_wdata); end
    checks++; if (mem_addr !== 16'h0020) begin errors++; $display("FAIL hstore_addr: got %h want 0020", mem_addr); end
    next_cycle();
    mem_ack = 1'b0;
    @(negedge clk);
    checks++; if ({rsp_valid, rsp_data, rsp_err} !== {1'b1, 32'h0, 2'b00}) begin errors++; $display("FAIL hstore_rsp: got %b/%h/%b want 1/0/00", rsp_valid, rsp_data, rsp_err); end
  endtask

  task automatic test_lanes();
    issue(1'b0, 3'b001, 16'h0002, 32'h0, 5'd1);
    mem_ack = 1'b1; mem_rdata = 32'h8001_7FFF;
    @(negedge clk);
    checks++; if (mem_byte_en !== 4'b1100) begin errors++; $display("FAIL uhalf_be: got %b want 1100", mem_byte_en); end
    next_cycle();
    mem_ack = 1'b0;
    @(negedge clk);
    checks++; if (rsp_data !== 32'h0000_8001) begin errors++; $display("FAIL uhalf_data: got %h want 00008001", rsp_data); end
    issue(1'b0, 3'b010, 16'h0000, 32'h0, 5'd2);
    mem_ack = 1'b1; mem_rdata = 32'h1234_9ABC;
    next_cycle();
    mem_ack = 1'b0;
    @(negedge clk);
    checks++; if (rsp_data !== 32'hFFFF_9ABC) begin errors++; $display("FAIL shalf_data: got %h want ffff9abc", rsp_data); end
    issue(1'b0, 3'b011, 16'h0012, 32'h0, 5'd4);
    mem_ack = 1'b1; mem_rdata = 32'h00F7_0000;
    next_cycle();
    mem_ack = 1'b0;
    @(negedge clk);
    checks++; if (rsp_data !== 32'h0000_00F7) begin errors++; $display("FAIL ubyte_data: got %h want 000000f7", rsp_data); end
    issue(1'b1, 3'b011, 16'h0001, 32'h0000_005A, 5'd5);
    mem_ack = 1'b1;
    @(negedge clk);
    checks++; if ({mem_byte_en, mem_wdata} !== {4'b0010, 32'h5A5A_5A5A}) begin errors++; $display("FAIL bstore_cmd: got %b/%h want 0010/5a5a5a5a", mem_byte_en, mem_wdata); end
    next_cycle();
    mem_ack = 1'b0;
    issue(1'b0, 3'b000, 16'h0100, 32'h0, 5'd0);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if ({mem_req, mem_byte_en} !== 5'b1_1111) begin errors++; $display("FAIL rd0_cmd: got %b want 11111", {mem_req, mem_byte_en}); end
    next_cycle();
    mem_ack = 1'b0;
    @(negedge clk);
    checks++; if ({rsp_valid, rsp_rd, rsp_data} !== {1'b1, 5'd0, 32'hDEAD_BEEF}) begin errors++; $display("FAIL rd0_rsp: got %b/%0d/%h want 1/0/deadbeef", rsp_valid, rsp_rd, rsp_data); end
  endtask

  task automatic test_errors();
    issue(1'b0, 3'b000, 16'h0005, 32'h0, 5'd9);
    @(negedge clk);
    checks++; if ({rsp_valid, rsp_err, mem_req} !== 4'b1010) begin errors++; $display("FAIL misalign_rsp: got %b want 1010", {rsp_valid, rsp_err, mem_req}); end
    checks++; if (rsp_rd !== 5'd9) begin errors++; $display("FAIL misalign_rd: got %0d want 9", rsp_rd); end
    next_cycle();
    @(negedge clk);
    checks++; if ({mem_req, rsp_valid} !== 2'b00) begin errors++; $display("FAIL misalign_after: got %b want 00", {mem_req, rsp_valid}); end
    issue(1'b0, 3'b110, 16'h0001, 32'h0, 5'd8);
    @(negedge clk);
    checks++; if ({rsp_valid, rsp_err, mem_req} !== 4'b1110) begin errors++; $display("FAIL badtype_rsp: got %b want 1110", {rsp_valid, rsp_err, mem_req}); end
  endtask

  task automatic test_timeout();
    issue(1'b0, 3'b000, 16'h0040, 32'h0, 5'd6);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL timeout_req_c%0d: got %b want 1", i, mem_req); end
      next_cycle();
    end
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    @(negedge clk);
    checks++; if ({mem_req, rsp_valid, rsp_err} !== 4'b0110) begin errors++; $display("FAIL timeout_rsp: got %b want 0110", {mem_req, rsp_valid, rsp_err}); end
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL timeout_data: got %h want 0", rsp_data); end
    next_cycle();
    @(negedge clk);
    checks++; if ({mem_req, rsp_valid, busy} !== 3'b000) begin errors++; $display("FAIL late_ack: got %b want 000", {mem_req, rsp_valid, busy}); end
    mem_ack = 1'b0;
  endtask

  task automatic test_halt_wait();
    issue(1'b0, 3'b000, 16'h0004, 32'h0, 5'd10);
    mem_rdata = 32'h1122_3344;
    for (int c = 1; c <= 5; c++) begin
      halt    = (c == 3 || c == 4);
      mem_ack = (c >= 3);
      @(negedge clk);
      checks++; if ({mem_req, mem_addr, rsp_valid, req_ready} !== {1'b1, 16'h0004, 2'b00}) begin errors++; $display("FAIL halt_hold_c%0d: got %b/%h/%b want 1/0004/00", c, mem_req, mem_addr, {rsp_valid, req_ready}); end
      next_cycle();
    end
    halt = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    checks++; if ({rsp_valid, rsp_data} !== {1'b1, 32'h1122_3344}) begin errors++; $display("FAIL halt_rsp: got %b/%h want 1/11223344", rsp_valid, rsp_data); end
    next_cycle();
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL halt_rsp_single: got %b want 0", rsp_valid); end
  endtask

  task automatic test_reset_mid_access();
    issue(1'b0, 3'b000, 16'h0080, 32'h0, 5'd11);
    @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rstmid_req: got %b want 1", mem_req); end
    rst = 1'b1; halt = 1'b1;
    next_cycle();
    rst = 1'b0; halt = 1'b0; mem_ack = 1'b1;
    @(negedge clk);
    checks++; if ({mem_req, rsp_valid, req_ready} !== 3'b001) begin errors++; $display("FAIL rstmid_after: got %b want 001", {mem_req, rsp_valid, req_ready}); end
    next_cycle();
    mem_ack = 1'b0;
    @(negedge clk);
    checks++; if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL rstmid_norsp: got %b want 00", {rsp_valid, busy}); end
  endtask

  initial begin
    rst = 1'b1; halt = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_type = 3'b000;
    req_addr = '0; req_wdata = '0; req_rd = '0; mem_ack = 1'b0; mem_rdata = '0;
    test_reset();
    test_sbyte_load();
    test_half_store();
    test_lanes();
    test_errors();
    test_timeout();
    test_halt_wait();
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
